// File: rtl/trdb_pkg.sv
// trdb_pkg: shared constants and types for the trace debug blocks.
//   PAYLOAD_LEN / P_LEN : payload bus and length field MSB indices.
//   MAX_BYTES           : largest legal payload length in bytes.
//   TS_LEN              : timestamp width.
//   encap_state_e       : encapsulator FSM states.
//   encap_entry_t       : one buffered packet (payload, length, optional timestamp).
// Optional feature macro: TRDB_ENCAP_TIMESTAMP_EN (adds the timestamp field).
package trdb_pkg;

  localparam int unsigned PAYLOAD_LEN = 47;
  localparam int unsigned P_LEN       = 3;
  localparam int unsigned MAX_BYTES   = (PAYLOAD_LEN + 1) / 8;
  localparam int unsigned TS_LEN      = 16;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    TS_LO,
    TS_HI,
    PAYLOAD
  } encap_state_e;

  typedef struct packed {
    logic [PAYLOAD_LEN:0] payload;
    logic [P_LEN:0]       length;
`ifdef TRDB_ENCAP_TIMESTAMP_EN
    logic [TS_LEN-1:0]    ts;
`endif
  } encap_entry_t;

  // Header byte: {timestamp present, flow, payload length}
  function automatic logic [7:0] encap_header(input logic ts_en,
                                              input logic [1:0] flow,
                                              input logic [P_LEN:0] len);
    return {ts_en, flow, 5'(len)};
  endfunction

endpackage

// File: rtl/trdb_encap_fifo.sv
// trdb_encap_fifo: synchronous FIFO of encap_entry_t.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push/wdata : write request and entry
//   pop/rdata  : read request; rdata shows the head entry combinationally
//   full/empty : status
//   count      : current occupancy (0..DEPTH)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only together with a pop.
module trdb_encap_fifo
  import trdb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  encap_entry_t             wdata,
  input  logic                     pop,
  output encap_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  encap_entry_t  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/trdb_encapsulator.sv
// trdb_encapsulator: buffers emitter packets and streams them out byte-serially
// as {header, [ts_lo, ts_hi], payload bytes LSB-first} over valid/ready.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   packet_payload_i  : payload, byte k at [8k+7:8k]
//   payload_length_i  : payload length in bytes (1..MAX_BYTES legal)
//   packet_valid_i    : one-cycle packet strobe (no backpressure)
//   out_data_o/out_valid_o/out_ready_i/out_last_o : byte stream to the sink
//   overflow_o        : one-cycle pulse per dropped packet (illegal length or FIFO full)
//   busy_o            : FIFO non-empty or FSM not idle
// Optional feature macro: TRDB_ENCAP_TIMESTAMP_EN (16-bit timestamp after header).
module trdb_encapsulator
  import trdb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  FLOW       = 2'b00
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PAYLOAD_LEN:0] packet_payload_i,
  input  logic [P_LEN:0]       payload_length_i,
  input  logic                 packet_valid_i,
  output logic [7:0]           out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_last_o,
  output logic                 overflow_o,
  output logic                 busy_o
);

  localparam int unsigned    AW      = $clog2(FIFO_DEPTH);
  localparam logic [P_LEN:0] MAX_LEN = (P_LEN + 1)'(MAX_BYTES);
  localparam logic [P_LEN:0] ONE     = (P_LEN + 1)'(1);
  localparam logic [P_LEN:0] TWO     = (P_LEN + 1)'(2);
`ifdef TRDB_ENCAP_TIMESTAMP_EN
  localparam logic           TS_EN   = 1'b1;
`else
  localparam logic           TS_EN   = 1'b0;
`endif

  encap_state_e         state, state_n;
  logic [PAYLOAD_LEN:0] shreg, shreg_n;
  logic [P_LEN:0]       cnt, cnt_n;
  logic [7:0]           data_q, data_n;
  logic                 valid_q, valid_n;
  logic                 last_q, last_n;
  logic                 ovf_q;
  logic                 busy_q, busy_n;

  encap_entry_t         wentry;
  encap_entry_t         head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [AW:0]          fifo_count;
  logic [AW:0]          occ_n;
  logic                 pop;
  logic                 len_ok;
  logic                 push_ok;
  logic                 reject;
  logic                 hs;

`ifdef TRDB_ENCAP_TIMESTAMP_EN
  logic [TS_LEN-1:0]    ts_cnt;
  logic [TS_LEN-1:0]    ts_q, ts_n;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  assign len_ok  = (payload_length_i != '0) && (payload_length_i <= MAX_LEN);
  // Full FIFO still accepts when the FSM pops in the same cycle.
  assign push_ok = packet_valid_i && len_ok && (!fifo_full || pop);
  assign reject  = packet_valid_i && !push_ok;
  assign hs      = valid_q && out_ready_i;

  always_comb begin
    wentry         = '0;
    wentry.payload = packet_payload_i;
    wentry.length  = payload_length_i;
`ifdef TRDB_ENCAP_TIMESTAMP_EN
    wentry.ts      = ts_cnt;
`endif
  end

  trdb_encap_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_ok),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    data_n  = data_q;
    valid_n = valid_q;
    last_n  = last_q;
    pop     = 1'b0;
`ifdef TRDB_ENCAP_TIMESTAMP_EN
    ts_n    = ts_q;
`endif

    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        if (!fifo_empty) pop = 1'b1;
      end
      HEADER: begin
        if (hs) begin
`ifdef TRDB_ENCAP_TIMESTAMP_EN
          state_n = TS_LO;
          data_n  = ts_q[7:0];
`else
          state_n = PAYLOAD;
          data_n  = shreg[7:0];
          last_n  = (cnt == ONE);
`endif
        end
      end
`ifdef TRDB_ENCAP_TIMESTAMP_EN
      TS_LO: begin
        if (hs) begin
          state_n = TS_HI;
          data_n  = ts_q[15:8];
        end
      end
      TS_HI: begin
        if (hs) begin
          state_n = PAYLOAD;
          data_n  = shreg[7:0];
          last_n  = (cnt == ONE);
        end
      end
`endif
      PAYLOAD: begin
        if (hs) begin
          if (cnt <= ONE) begin
            // Last byte accepted: chain straight into the next packet if one waits.
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_n = IDLE;
              valid_n = 1'b0;
              last_n  = 1'b0;
            end
          end else begin
            shreg_n = shreg >> 8;
            cnt_n   = cnt - ONE;
            data_n  = shreg[15:8];
            last_n  = (cnt == TWO);
          end
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        last_n  = 1'b0;
      end
    endcase

    // Any pop loads the head entry and presents its header next cycle.
    if (pop) begin
      state_n = HEADER;
      shreg_n = head.payload;
      cnt_n   = head.length;
      data_n  = encap_header(TS_EN, FLOW, head.length);
      valid_n = 1'b1;
      last_n  = 1'b0;
`ifdef TRDB_ENCAP_TIMESTAMP_EN
      ts_n    = head.ts;
`endif
    end

    occ_n  = fifo_count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
    busy_n = (state_n != IDLE) || (occ_n != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef TRDB_ENCAP_TIMESTAMP_EN
      ts_q    <= '0;
`endif
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      cnt     <= cnt_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      ovf_q   <= reject;
      busy_q  <= busy_n;
`ifdef TRDB_ENCAP_TIMESTAMP_EN
      ts_q    <= ts_n;
`endif
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_trdb_encapsulator.sv
// Testbench for trdb_encapsulator: directed scenarios plus randomized traffic,
// expected byte stream pushed to a scoreboard queue, checked by a monitor.
module tb_trdb_encapsulator;
  import trdb_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam logic [1:0]  FLOW_V = 2'b10;
`ifdef TRDB_ENCAP_TIMESTAMP_EN
  localparam int TS = 1;
`else
  localparam int TS = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic [PAYLOAD_LEN:0] packet_payload_i = '0;
  logic [P_LEN:0]       payload_length_i = '0;
  logic                 packet_valid_i = 1'b0;
  logic [7:0]           out_data_o;
  logic                 out_valid_o;
  logic                 out_ready_i = 1'b0;
  logic                 out_last_o;
  logic                 overflow_o;
  logic                 busy_o;

  trdb_encapsulator #(
    .FIFO_DEPTH (DEPTH),
    .FLOW       (FLOW_V)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .packet_payload_i (packet_payload_i),
    .payload_length_i (payload_length_i),
    .packet_valid_i   (packet_valid_i),
    .out_data_o       (out_data_o),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_last_o       (out_last_o),
    .overflow_o       (overflow_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int        cyc = 0;
  int        checks = 0;
  int        passed = 0;
  int        outstanding = 0;
  int        rmode = 3;
  logic [8:0] exp_q[$];
  bit        ovf_exp[int];

  always @(posedge clk) cyc <= cyc + 1;

`ifdef TRDB_ENCAP_TIMESTAMP_EN
  logic [15:0] tsc;
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) tsc <= 16'h0;
    else       tsc <= tsc + 16'h1;
  end
`endif

  task automatic chk(input bit ok, input string nm, input longint act, input longint exv);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exv, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready driver: 0 always high, 1 pattern 1,0,0,1, 2 random, 3 low, 4 manual.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready_i = 1'b1;
        1: out_ready_i = (ph % 4 == 0) || (ph % 4 == 3);
        2: out_ready_i = 1'($urandom_range(0, 1));
        3: out_ready_i = 1'b0;
        default: ;
      endcase
      ph++;
    end
  end

  // Issue one strobe; record the expected bytes or the expected overflow pulse.
  task automatic push_pkt(input logic [47:0] pl, input int len, input bit expect_ok);
    packet_valid_i   = 1'b1;
    packet_payload_i = pl;
    payload_length_i = (P_LEN + 1)'(len);
    if (expect_ok) begin
      int hdr;
      hdr = (TS ? 128 : 0) + int'(FLOW_V) * 32 + len;
      exp_q.push_back({1'b0, 8'(hdr)});
`ifdef TRDB_ENCAP_TIMESTAMP_EN
      exp_q.push_back({1'b0, tsc[7:0]});
      exp_q.push_back({1'b0, tsc[15:8]});
`endif
      for (int k = 0; k < len; k++)
        exp_q.push_back({(k == len - 1), 8'(pl >> (8 * k))});
      outstanding++;
    end else begin
      ovf_exp[cyc + 1] = 1'b1;
    end
    tick();
    packet_valid_i = 1'b0;
  endtask

  task automatic drain(input int maxc);
    bit done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_o) begin
        done = 1'b1;
        break;
      end
    end
    chk(done, "drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  // Monitor: overflow pulses, handshaken bytes, and hold-while-stalled.
  initial begin
    bit        prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic      prev_last = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        prev_stall = 1'b0;
        continue;
      end
      chk(overflow_o == ovf_exp.exists(cyc), "overflow", overflow_o, ovf_exp.exists(cyc));
      if (prev_stall) begin
        chk(out_valid_o == 1'b1, "hold_valid", out_valid_o, 1);
        chk(out_data_o == prev_data, "hold_data", out_data_o, prev_data);
        chk(out_last_o == prev_last, "hold_last", out_last_o, prev_last);
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_byte", {out_last_o, out_data_o}, 0);
        end else begin
          e = exp_q.pop_front();
          chk({out_last_o, out_data_o} == e, "byte", {out_last_o, out_data_o}, e);
          if (e[8]) outstanding--;
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      prev_last  = out_last_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    bit seen;
    logic [47:0] pl;
    int len;

    // Reset state
    repeat (3) tick();
    chk(out_valid_o == 0, "rst_valid", out_valid_o, 0);
    chk(out_last_o == 0, "rst_last", out_last_o, 0);
    chk(out_data_o == 0, "rst_data", out_data_o, 0);
    chk(overflow_o == 0, "rst_overflow", overflow_o, 0);
    chk(busy_o == 0, "rst_busy", busy_o, 0);
    rst_i = 1'b0;
    rmode = 0;
    tick();

    // Single packet and latency
    c0 = cyc;
    push_pkt(48'h0000_00CC_BBAA, 3, 1);
    @(negedge clk);
    chk(out_valid_o == 0, "latency_early", out_valid_o, 0);
    @(negedge clk);
    chk(out_valid_o == 1 && cyc == c0 + 2, "latency_hdr", cyc - c0, 2);
    drain(50);

    // Backpressure
    rmode = 1;
    push_pkt(48'h0000_00CC_BBAA, 3, 1);
    drain(100);

    // Back-to-back with no bubble
    rmode = 0;
    tick();
    push_pkt(48'h0000_0000_2211, 2, 1);
    push_pkt(48'h0000_0000_0033, 1, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid_o;
    end
    chk(seen, "b2b_start", seen, 1);
    for (int i = 0; i < 4 + 2 * TS * 2; i++) begin
      @(negedge clk);
      chk(out_valid_o == 1, "b2b_no_bubble", out_valid_o, 1);
    end
    drain(50);

    // Overflow: one packet stalled in the FSM, 4 fill the FIFO, the 5th drops
    rmode = 3;
    repeat (2) tick();
    push_pkt(48'h0000_0000_00A0, 1, 1);
    repeat (3) tick();
    for (int i = 1; i <= 5; i++)
      push_pkt(48'h0000_0000_B000 | 48'(i), 2, (i <= 4));
    repeat (3) tick();
    // Full FIFO plus a same-cycle pop accepts the push
    rmode = 4;
    tick();
    out_ready_i = 1'b1;
    tick();
    repeat (2 * TS) tick();
    push_pkt(48'h0000_0000_00C7, 1, 1);
    rmode = 0;
    drain(200);

    // Illegal lengths
    push_pkt(48'h0000_0000_1234, 0, 0);
    push_pkt(48'h0000_0000_5678, MAX_BYTES + 1, 0);
    repeat (4) tick();
    chk(busy_o == 0, "illegal_busy", busy_o, 0);
    drain(20);

    // Reset mid-payload, then a clean packet
    push_pkt(48'h6655_4433_2211, 6, 1);
    repeat (3 + 2 * TS) @(negedge clk);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    chk(out_valid_o == 0, "rst_mid_valid", out_valid_o, 0);
    chk(busy_o == 0, "rst_mid_busy", busy_o, 0);
    exp_q.delete();
    ovf_exp.delete();
    outstanding = 0;
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    push_pkt(48'h0000_0000_BEEF, 2, 1);
    drain(50);

    // Randomized traffic with random ready
    rmode = 2;
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      if (outstanding < int'(DEPTH)) begin
        pl  = {16'($urandom()), $urandom()};
        len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) * (MAX_BYTES + 1)
                                          : int'($urandom_range(1, MAX_BYTES));
        push_pkt(pl, len, (len >= 1 && len <= MAX_BYTES));
      end else begin
        tick();
      end
    end
    rmode = 0;
    drain(500);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
